amstrad_mem_arbiter: RTL
========================

// Module: amstrad_mem_arbiter
// PURPOSE
// Shares the single external memory port between three requesters: the video fetch
// (15-bit word address from the CRTC/Gate Array path), the Z80 memory cycle (23-bit
// MMU-mapped byte address) and the ROM/disk download loader. It sits between
// Amstrad_motherboard and the SDRAM controller and performs one access at a time
// under fixed priority.
// PARAMETERS
// VID_BASE  23'h000000  byte base of video RAM; video byte addr = VID_BASE + {vid_addr,1'b0}
// TIMEOUT   8'd255      cycles to wait for mem_ack before aborting an access
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous, active-high reset
// vid_req    in   1   1-cycle pulse: fetch one 16-bit video word
// vid_addr   in   15  video word address, sampled with vid_req
// vid_data   out  16  fetched word, valid from vid_ack onward
// vid_ack    out  1   1-cycle pulse: vid_data updated
// cpu_rd     in   1   CPU memory read, level
// cpu_wr     in   1   CPU memory write, level
// cpu_addr   in   23  CPU byte address, sampled at access start
// cpu_din    in   8   CPU write data, sampled at access start
// cpu_dout   out  8   CPU read data, held until the next CPU read completes
// cpu_ready  out  1   low while a CPU access is pending/in flight
// dl_wr      in   1   1-cycle pulse: loader byte write
// dl_addr    in   23  loader byte address
// dl_data    in   8   loader byte
// dl_busy    out  1   high while a loader write is pending/in flight
// dl_ovf     out  1   sticky: dl_wr arrived while dl_busy; cleared only by reset
// mem_req    out  1   request to SDRAM controller, held until mem_ack
// mem_we     out  1   write strobe, valid with mem_req
// mem_addr   out  23  byte address, valid with mem_req
// mem_be     out  2   byte enables (video 2'b11; byte access: addr[0] ? 2'b10 : 2'b01)
// mem_wdata  out  16  write data, the byte replicated on both lanes
// mem_rdata  in   16  read data, valid in the mem_ack cycle
// mem_ack    in   1   1-cycle completion pulse
// timeout    out  1   1-cycle pulse: an access was aborted
// BEHAVIOUR
// - Reset (async): state IDLE; all pending flags clear; mem_req, mem_we, vid_ack,
//   timeout, dl_busy, dl_ovf = 0; mem_addr, mem_be, mem_wdata, vid_data, cpu_dout = 0;
//   cpu_ready = 1. An in-flight access is dropped and mem_req falls immediately.
// - Pending latches: vid_pend is set by vid_req, capturing vid_addr. dl_pend is set
//   by dl_wr, capturing addr/data, but only when dl_busy=0. A dl_wr with dl_busy=1 is
//   ignored and sets dl_ovf. cpu_pend is set on a rising edge of (cpu_rd|cpu_wr)
//   only: one access per assertion. If both rd and wr are high, it is a write.
// - cpu_ready falls in the cycle after the edge and rises in the cycle after the
//   completion or abort. dl_busy is high from the cycle after dl_wr until the
//   cycle after completion.
// - A set and a clear of the same pending flag in one cycle: the set wins. This
//   covers vid_req arriving in the ack cycle of the previous fetch.
// - FSM: IDLE -> VID | DL | CPU, chosen by priority vid > dl > cpu among pending
//   flags. Entering a state registers mem_req=1 with addr/we/be/wdata.
//   VID/DL/CPU -> IDLE on mem_ack; the flag clears and the result is latched.
//   Video: vid_data <= mem_rdata, and vid_ack pulses in the same cycle as the
//   latch. CPU read: cpu_dout <= addr[0] ? mem_rdata[15:8] : mem_rdata[7:0].
// - After a grant there is always one IDLE cycle, so mem_req drops for at least
//   1 cycle between accesses. There is no preemption: a granted access always runs
//   to ack or timeout.
// - Latency from a request to mem_req with idle arbiter and no competitors:
//   2 cycles (latch, then grant).
// - Timeout: a per-access counter counts cycles with mem_req=1 and no ack. When it
//   reaches TIMEOUT: mem_req <= 0, timeout pulses, the flag clears, return to IDLE.
//   Read data is not updated, and vid_ack does not pulse on abort.
// - mem_addr arithmetic: 23-bit modulo, so VID_BASE + offset wraps past 23'h7FFFFF.
// - A mem_ack arriving while mem_req=0 (including in IDLE) is ignored.
// TESTING
// - Video read: vid_req, vid_addr=15'h1234, VID_BASE=0 -> mem_addr=23'h002468,
//   mem_be=11; on ack with mem_rdata=16'hBEEF -> vid_data=BEEF and one vid_ack pulse.
// - Contention: cpu_rd, dl_wr and vid_req in the same cycle -> grant order is
//   VID, then DL, then CPU, with an idle gap (mem_req=0 for 1 cycle) between each.
// - CPU byte lanes: cpu_wr addr=23'h00C001, din=8'hA5 -> mem_be=10, mem_wdata=A5A5;
//   read of the same address with rdata=16'h5A00 -> cpu_dout=5A and cpu_ready rises.
// - Loader overflow: two dl_wr pulses 1 cycle apart -> only the first is written;
//   dl_ovf=1 and stays set.
// - Timeout: mem_ack is never returned -> after 255 cycles mem_req falls, timeout
//   pulses and cpu_ready returns to 1; the next vid_req is serviced normally.
// - Reset mid-access: assert reset while mem_req=1 -> mem_req=0 with no clock edge;
//   after release the FSM is IDLE with no stale grant.

Source files
------------

// File: rtl/amstrad_mem_arbiter.sv
// Fixed-priority arbiter that shares one SDRAM port between the video fetch, the
// Z80 memory cycle and the download loader. It runs one access at a time.
module amstrad_mem_arbiter #(
    parameter logic [22:0] VID_BASE = 23'h000000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ready,
    input  logic        dl_wr,
    input  logic [22:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_busy,
    output logic        dl_ovf,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, VID, DL, CPU} state_t;

    state_t      state, next_state;
    logic        vid_pend, dl_pend, cpu_pend;
    logic        cpu_prev, cpu_we_q;
    logic [14:0] vid_addr_q;
    logic [22:0] dl_addr_q, cpu_addr_q;
    logic [7:0]  dl_data_q, cpu_din_q;
    logic [7:0]  wait_cnt;

    logic grant_vid, grant_dl, grant_cpu;
    logic done_ok, abort;
    logic vid_done, dl_done, cpu_done;
    logic cpu_edge;

    assign cpu_edge  = (cpu_rd | cpu_wr) & ~cpu_prev;
    assign cpu_ready = ~cpu_pend;
    assign dl_busy   = dl_pend;
    assign vid_done  = (state == VID) && (done_ok || abort);
    assign dl_done   = (state == DL)  && (done_ok || abort);
    assign cpu_done  = (state == CPU) && (done_ok || abort);

    always_comb begin
        next_state = state;
        grant_vid  = 1'b0;
        grant_dl   = 1'b0;
        grant_cpu  = 1'b0;
        done_ok    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (vid_pend) begin
                    next_state = VID;
                    grant_vid  = 1'b1;
                end else if (dl_pend) begin
                    next_state = DL;
                    grant_dl   = 1'b1;
                end else if (cpu_pend) begin
                    next_state = CPU;
                    grant_cpu  = 1'b1;
                end
            end
            default: begin
                if (mem_req && mem_ack) begin
                    done_ok    = 1'b1;
                    next_state = IDLE;
                end else if (mem_req && wait_cnt == TIMEOUT - 8'd1) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Pending flags: a new request in the same cycle as completion keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_pend   <= 1'b0;
            dl_pend    <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_prev   <= 1'b0;
            cpu_we_q   <= 1'b0;
            dl_ovf     <= 1'b0;
            vid_addr_q <= '0;
            dl_addr_q  <= '0;
            dl_data_q  <= '0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
        end else begin
            cpu_prev <= cpu_rd | cpu_wr;
            if (vid_req) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end else if (vid_done) begin
                vid_pend <= 1'b0;
            end
            if (dl_wr && !dl_pend) begin
                dl_pend   <= 1'b1;
                dl_addr_q <= dl_addr;
                dl_data_q <= dl_data;
            end else if (dl_done) begin
                dl_pend <= 1'b0;
            end
            if (dl_wr && dl_pend) dl_ovf <= 1'b1;
            if (cpu_edge) begin
                cpu_pend   <= 1'b1;
                cpu_we_q   <= cpu_wr;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end else if (cpu_done) begin
                cpu_pend <= 1'b0;
            end
        end
    end

    // Memory port drive, result capture and the per-access timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            vid_data  <= '0;
            vid_ack   <= 1'b0;
            cpu_dout  <= '0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            vid_ack <= vid_done && done_ok;
            timeout <= abort;
            if (grant_vid) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= VID_BASE + {7'd0, vid_addr_q, 1'b0};
                mem_be    <= 2'b11;
                mem_wdata <= '0;
                wait_cnt  <= '0;
            end else if (grant_dl) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= dl_addr_q;
                mem_be    <= dl_addr_q[0] ? 2'b10 : 2'b01;
                mem_wdata <= {dl_data_q, dl_data_q};
                wait_cnt  <= '0;
            end else if (grant_cpu) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we_q;
                mem_addr  <= cpu_addr_q;
                mem_be    <= cpu_addr_q[0] ? 2'b10 : 2'b01;
                mem_wdata <= {cpu_din_q, cpu_din_q};
                wait_cnt  <= '0;
            end else if (done_ok || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end else if (mem_req) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (vid_done && done_ok) vid_data <= mem_rdata;
            if (cpu_done && done_ok && !mem_we)
                cpu_dout <= mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        end
    end

endmodule
